collatz_step_checker: RTL and testbench

//  Reader/checker at the far end of the Collatz uDATAPATH output bus (uo_out).
//  - Loads a seed on start, then samples the datapath output bus.
//  - Accepts only values that have stayed stable for a set number of cycles.
//  - Checks each accepted value against the Collatz rule, counts steps, tracks the peak value.
//  - Reports done at 1, or an error. Used as on-chip self-check and as the bench reference.

---
 rtl/collatz_step_checker_pkg.sv | 34 +++
 rtl/collatz_step_checker_settle_filter.sv | 60 ++++++
 rtl/collatz_step_checker.sv | 196 +++++++++++++++++++
 tb/tb_collatz_step_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_step_checker_pkg.sv
// Package collatz_pkg: shared state encoding, error codes and the Collatz
// next-value helper for the collatz_step_checker slice.
package collatz_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SEED = 3'd1,
    TRACK     = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_SEED     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Returns {overflow, next}. The arithmetic is done two bits wider than any
  // bus up to 32 bits, so 3n+1 never wraps before the overflow test; overflow
  // is set when the result does not fit in 'width' bits.
  function automatic logic [32:0] collatz_next(input logic [31:0] n,
                                               input int unsigned width);
    logic [33:0] wide;
    logic        ovf;
    if (n[0]) begin
      wide = ({2'b00, n} << 1) + {2'b00, n} + 34'd1;
    end else begin
      wide = {2'b00, n >> 1};
    end
    ovf = (wide >> width) != 34'd0;
    return {ovf, wide[31:0]};
  endfunction

endpackage

// File: rtl/collatz_step_checker_settle_filter.sv
// collatz_settle_filter: accepts a bus value once it has been sampled equal
// on SETTLE_CYCLES consecutive clock edges. The accept pulse is combinational
// so the consumer can update its registers on the acceptance edge itself.
module collatz_settle_filter
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             accept_o,
  output logic [WIDTH-1:0] value_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sample_q;
  logic             sameSample;

  // A zero count means no valid previous sample, so the first edge after a
  // clear or reset always starts a fresh run of length one.
  assign sameSample = (count_q != '0) && (data_i == sample_q);
  assign value_o    = data_i;

  // Run-length counter: saturates at SETTLE_MAX so a held value pulses once.
  always_comb begin
    count_d  = CW'(1);
    accept_o = 1'b0;
    if (sameSample) begin
      if (count_q == SETTLE_MAX) begin
        count_d = count_q;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
    if ((count_d == SETTLE_MAX) && !(sameSample && (count_q == SETTLE_MAX))) begin
      accept_o = 1'b1;
    end
    if (clear_i) begin
      count_d = '0;
    end
  end

  // Sample register and run-length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      sample_q <= '0;
    end else begin
      count_q  <= count_d;
      sample_q <= data_i;
    end
  end

endmodule

// File: rtl/collatz_step_checker.sv
// collatz_step_checker: watches the Collatz datapath output bus, accepts
// settled values and checks each one against the Collatz rule, counting steps
// and tracking the peak value.
// Optional feature: define COLLATZ_TIMEOUT_EN to enable a watchdog that flags
// err_code 11 after TIMEOUT_CYCLES cycles without an accepted value.
module collatz_step_checker
  import collatz_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS  = 8,
  parameter int unsigned DATAWIDTH_STEP = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATAWIDTH_BUS-1:0]  seed_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]  data_InBUS,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic                      overflow,
  output logic [DATAWIDTH_STEP-1:0] step_count,
  output logic [DATAWIDTH_BUS-1:0]  peak_value
);

  state_e                    state_q, state_d;
  logic [DATAWIDTH_BUS-1:0]  expected_q, expected_d;
  logic [DATAWIDTH_BUS-1:0]  lastAccepted_q, lastAccepted_d;
  logic [DATAWIDTH_BUS-1:0]  peak_q, peak_d;
  logic [DATAWIDTH_STEP-1:0] stepCount_q, stepCount_d;
  logic [1:0]                errCode_q, errCode_d;
  logic                      overflow_q, overflow_d;

  logic                      startTake;
  logic                      accept;
  logic [DATAWIDTH_BUS-1:0]  acceptValue;
  logic [32:0]               nextRes;
  logic                      nextOvf;
  logic [DATAWIDTH_BUS-1:0]  nextVal;
  logic                      unusedNextBits;

`ifdef COLLATZ_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wdog_q, wdog_d;
`endif

  // A start is honoured only when not busy; it also restarts the settle count
  // so a bus already sitting at the seed still has to settle afresh.
  assign startTake = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

  collatz_settle_filter #(
    .WIDTH         (DATAWIDTH_BUS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (startTake),
    .data_i   (data_InBUS),
    .accept_o (accept),
    .value_o  (acceptValue)
  );

  assign nextRes        = collatz_next(32'(acceptValue), DATAWIDTH_BUS);
  assign nextOvf        = nextRes[32];
  assign nextVal        = nextRes[DATAWIDTH_BUS-1:0];
  assign unusedNextBits = ^nextRes[31:DATAWIDTH_BUS];

  assign busy       = (state_q == WAIT_SEED) || (state_q == TRACK);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign err_code   = errCode_q;
  assign overflow   = overflow_q;
  assign step_count = stepCount_q;
  assign peak_value = peak_q;

  // Next-state logic: seed handling, stable-value checking and optional watchdog.
  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    lastAccepted_d = lastAccepted_q;
    peak_d         = peak_q;
    stepCount_d    = stepCount_q;
    errCode_d      = errCode_q;
    overflow_d     = overflow_q;
`ifdef COLLATZ_TIMEOUT_EN
    wdog_d         = '0;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          expected_d     = seed_InBUS;
          lastAccepted_d = seed_InBUS;
          peak_d         = seed_InBUS;
          stepCount_d    = '0;
          errCode_d      = ERR_NONE;
          overflow_d     = 1'b0;
          if (seed_InBUS == '0) begin
            state_d   = ERROR;
            errCode_d = ERR_SEED;
          end else if (seed_InBUS == DATAWIDTH_BUS'(1)) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_SEED;
          end
        end
      end
      WAIT_SEED: begin
        if (accept && (acceptValue == expected_q)) begin
          lastAccepted_d = acceptValue;
          if (nextOvf) begin
            state_d    = DONE;
            overflow_d = 1'b1;
          end else begin
            state_d    = TRACK;
            expected_d = nextVal;
          end
        end
      end
      TRACK: begin
        if (accept && (acceptValue != lastAccepted_q)) begin
          lastAccepted_d = acceptValue;
          if (acceptValue == expected_q) begin
            if (stepCount_q != '1) begin
              stepCount_d = stepCount_q + DATAWIDTH_STEP'(1);
            end
            if (acceptValue > peak_q) begin
              peak_d = acceptValue;
            end
            if (acceptValue == DATAWIDTH_BUS'(1)) begin
              state_d = DONE;
            end else if (nextOvf) begin
              state_d    = DONE;
              overflow_d = 1'b1;
            end else begin
              expected_d = nextVal;
            end
          end else begin
            state_d   = ERROR;
            errCode_d = ERR_MISMATCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef COLLATZ_TIMEOUT_EN
    if ((state_q == WAIT_SEED) || (state_q == TRACK)) begin
      if (accept) begin
        wdog_d = '0;
      end else if ((wdog_q + WDW'(1)) == WDW'(TIMEOUT_CYCLES)) begin
        wdog_d    = '0;
        state_d   = ERROR;
        errCode_d = ERR_TIMEOUT;
      end else begin
        wdog_d = wdog_q + WDW'(1);
      end
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      expected_q     <= '0;
      lastAccepted_q <= '0;
      peak_q         <= '0;
      stepCount_q    <= '0;
      errCode_q      <= ERR_NONE;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      lastAccepted_q <= lastAccepted_d;
      peak_q         <= peak_d;
      stepCount_q    <= stepCount_d;
      errCode_q      <= errCode_d;
      overflow_q     <= overflow_d;
    end
  end

`ifdef COLLATZ_TIMEOUT_EN
  // Watchdog counter: cycles since the last accepted value while checking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

endmodule

// File: tb/tb_collatz_step_checker.sv
// Directed testbench for collatz_step_checker. Inputs change 1ns after the
// rising edge and outputs are sampled there too, away from the active edge.
module tb_collatz_step_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] seed_InBUS;
  logic [7:0] data_InBUS;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic       overflow;
  logic [7:0] step_count;
  logic [7:0] peak_value;

  int checkCount = 0;
  int failCount  = 0;

  collatz_step_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed_InBUS (seed_InBUS),
    .data_InBUS (data_InBUS),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .overflow   (overflow),
    .step_count (step_count),
    .peak_value (peak_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global guard so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout got=stuck want=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStart(input logic [7:0] s);
    start      = 1'b1;
    seed_InBUS = s;
    tick();
    start      = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] v, input int cycles);
    data_InBUS = v;
    repeat (cycles) tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    seed_InBUS = 8'd0;
    data_InBUS = 8'd0;
    #12;
    checkCount++;
    if ({busy, done, error, err_code, overflow, step_count, peak_value} !== 22'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs got=%h want=0",
               {busy, done, error, err_code, overflow, step_count, peak_value});
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    logic [7:0] vals [7] = '{8'd10, 8'd5, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};
    data_InBUS = 8'd6;
    applyStart(8'd6);
    checkCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL seq_busy got=%0b want=1", busy); end
    applyStimulus(8'd6, 4);
    applyStimulus(8'd3, 4);
    checkCount++;
    if (step_count !== 8'd1) begin failCount++; $display("[TB] FAIL seq_step1 got=%0d want=1", step_count); end
    foreach (vals[i]) applyStimulus(vals[i], 4);
    checkCount++;
    if (done !== 1'b1) begin failCount++; $display("[TB] FAIL seq_done got=%0b want=1", done); end
    checkCount++;
    if (step_count !== 8'd8) begin failCount++; $display("[TB] FAIL seq_steps got=%0d want=8", step_count); end
    checkCount++;
    if (peak_value !== 8'd16) begin failCount++; $display("[TB] FAIL seq_peak got=%0d want=16", peak_value); end
    checkCount++;
    if ({error, busy, overflow} !== 3'b000) begin
      failCount++; $display("[TB] FAIL seq_flags got=%b want=000", {error, busy, overflow});
    end
  endtask

  task automatic test_mismatch();
    data_InBUS = 8'd7;
    applyStart(8'd7);
    applyStimulus(8'd7, 4);
    applyStimulus(8'd21, 4);
    checkCount++;
    if (error !== 1'b1) begin failCount++; $display("[TB] FAIL mis_error got=%0b want=1", error); end
    checkCount++;
    if (err_code !== 2'b01) begin failCount++; $display("[TB] FAIL mis_code got=%b want=01", err_code); end
    checkCount++;
    if (step_count !== 8'd0) begin failCount++; $display("[TB] FAIL mis_steps got=%0d want=0", step_count); end
    applyStimulus(8'd22, 6);
    checkCount++;
    if ({error, busy, done} !== 3'b100) begin
      failCount++; $display("[TB] FAIL mis_hold got=%b want=100", {error, busy, done});
    end
  endtask

  task automatic test_seed_edges();
    applyStart(8'd0);
    checkCount++;
    if ({error, err_code, busy} !== 4'b1100) begin
      failCount++; $display("[TB] FAIL seed0 got=%b want=1100", {error, err_code, busy});
    end
    applyStart(8'd1);
    checkCount++;
    if ({done, error, err_code, busy} !== 5'b10000) begin
      failCount++; $display("[TB] FAIL seed1_flags got=%b want=10000", {done, error, err_code, busy});
    end
    checkCount++;
    if ({step_count, peak_value} !== {8'd0, 8'd1}) begin
      failCount++; $display("[TB] FAIL seed1_regs got=%0d/%0d want=0/1", step_count, peak_value);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] vals [6] = '{8'd5, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};
    data_InBUS = 8'd3;
    applyStart(8'd3);
    applyStimulus(8'd3, 4);
    applyStimulus(8'd6, 2);
    applyStimulus(8'd9, 3);
    applyStimulus(8'd6, 1);
    applyStimulus(8'd10, 4);
    checkCount++;
    if ({busy, error} !== 2'b10) begin
      failCount++; $display("[TB] FAIL glitch_flags got=%b want=10", {busy, error});
    end
    checkCount++;
    if ({step_count, peak_value} !== {8'd1, 8'd10}) begin
      failCount++; $display("[TB] FAIL glitch_regs got=%0d/%0d want=1/10", step_count, peak_value);
    end
    applyStart(8'd0);
    checkCount++;
    if ({busy, error, err_code} !== 4'b1000) begin
      failCount++; $display("[TB] FAIL busy_start got=%b want=1000", {busy, error, err_code});
    end
    foreach (vals[i]) applyStimulus(vals[i], 4);
    checkCount++;
    if ({done, step_count, peak_value} !== {1'b1, 8'd7, 8'd16}) begin
      failCount++;
      $display("[TB] FAIL glitch_end got=%0b/%0d/%0d want=1/7/16", done, step_count, peak_value);
    end
  endtask

  task automatic test_overflow();
    data_InBUS = 8'd171;
    applyStart(8'd171);
    applyStimulus(8'd171, 4);
    checkCount++;
    if ({done, overflow, error, busy} !== 4'b1100) begin
      failCount++; $display("[TB] FAIL ovf_flags got=%b want=1100", {done, overflow, error, busy});
    end
    checkCount++;
    if ({step_count, peak_value} !== {8'd0, 8'd171}) begin
      failCount++; $display("[TB] FAIL ovf_regs got=%0d/%0d want=0/171", step_count, peak_value);
    end
  endtask

  task automatic test_reset_mid();
    data_InBUS = 8'd6;
    applyStart(8'd6);
    checkCount++;
    if ({busy, overflow} !== 2'b10) begin
      failCount++; $display("[TB] FAIL restart_clear got=%b want=10", {busy, overflow});
    end
    applyStimulus(8'd6, 4);
    applyStimulus(8'd3, 4);
    applyStimulus(8'd10, 2);
    checkCount++;
    if (step_count !== 8'd1) begin failCount++; $display("[TB] FAIL mid_step got=%0d want=1", step_count); end
    #3 rst_n = 1'b0;
    #2;
    checkCount++;
    if ({busy, done, error, err_code, overflow, step_count, peak_value} !== 22'd0) begin
      failCount++;
      $display("[TB] FAIL mid_reset got=%h want=0",
               {busy, done, error, err_code, overflow, step_count, peak_value});
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    data_InBUS = 8'd5;
    applyStart(8'd5);
    applyStimulus(8'd5, 4);
    repeat (1023) tick();
    checkCount++;
    if ({busy, error} !== 2'b10) begin
      failCount++; $display("[TB] FAIL wdog_early got=%b want=10", {busy, error});
    end
    tick();
`ifdef COLLATZ_TIMEOUT_EN
    checkCount++;
    if ({error, err_code, busy} !== 4'b1110) begin
      failCount++; $display("[TB] FAIL wdog_fire got=%b want=1110", {error, err_code, busy});
    end
`else
    checkCount++;
    if ({error, err_code, busy} !== 4'b0001) begin
      failCount++; $display("[TB] FAIL wdog_absent got=%b want=0001", {error, err_code, busy});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_mismatch();
    test_seed_edges();
    test_glitch();
    test_overflow();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
